// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath word width, word type and the result-register
// occupancy states used by the shared adder.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Result register occupancy: EMPTY has nothing to present, FULL holds a result.
  typedef enum logic [0:0] {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle for the shared adder: NREQ packed request channels
// in, one registered result channel out.
interface adder_arbiter_if
  import cpu_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WORD_W-1:0] req_a;
  logic [NREQ*WORD_W-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  word_t                  rsp_sum;
  logic                   rsp_carry;
  logic [IDW-1:0]         rsp_id;

  // Requesters and result consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
  );

  // Shared adder side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
  );

endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr, wrapping
// modulo NREQ, and grants the first set bit. No grant while en is low.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  int   idx_s;
  logic found_s;

  // Priority search from ptr upwards with wrap; first valid requester wins.
  always_comb begin
    gnt     = {NREQ{1'b0}};
    gnt_idx = {IDW{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr) + k) % NREQ;
      if (en && !found_s && req[idx_s]) begin
        found_s      = 1'b1;
        gnt[idx_s]   = 1'b1;
        gnt_idx      = IDW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shared 32-bit adder: round-robin grants one requester per cycle, adds its
// operands and holds the result with the requester ID in a one-entry register.
module adder_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input logic            clk,
  input logic            rst,
  adder_arbiter_if.slave bus
);

  rsp_state_e      state_r;
  rsp_state_e      state_nxt_s;
  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  ptr_nxt_s;
  logic [NREQ-1:0] gnt_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic            can_accept_s;
  logic            arb_en_s;
  logic            xfer_s;
  word_t           op_a_s;
  word_t           op_b_s;
  logic [WORD_W:0] sum_s;
  word_t           sum_r;
  logic            carry_r;
  logic [IDW-1:0]  id_r;

  // A slot is free when empty or when the held result drains this cycle;
  // nothing is granted while reset is asserted.
  assign can_accept_s = (state_r == RSP_EMPTY) | bus.rsp_ready;
  assign arb_en_s     = can_accept_s & ~rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_r),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign xfer_s = |(gnt_s & bus.req_valid);

  // Select the winner's operands and form the single 33-bit sum.
  always_comb begin
    op_a_s = bus.req_a[int'(gnt_idx_s)*WORD_W +: WORD_W];
    op_b_s = bus.req_b[int'(gnt_idx_s)*WORD_W +: WORD_W];
    sum_s  = {1'b0, op_a_s} + {1'b0, op_b_s};
  end

  // Pointer moves just past the winner on a transfer, wrapping at NREQ-1.
  always_comb begin
    if (xfer_s) begin
      if (gnt_idx_s == IDW'(NREQ - 1)) begin
        ptr_nxt_s = {IDW{1'b0}};
      end else begin
        ptr_nxt_s = gnt_idx_s + IDW'(1'b1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {IDW{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Result-register occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RSP_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next occupancy: a transfer always fills; a drain without transfer empties.
  always_comb begin
    case (state_r)
      RSP_EMPTY: begin
        if (xfer_s) begin
          state_nxt_s = RSP_FULL;
        end else begin
          state_nxt_s = RSP_EMPTY;
        end
      end
      RSP_FULL: begin
        if (xfer_s) begin
          state_nxt_s = RSP_FULL;
        end else if (bus.rsp_ready) begin
          state_nxt_s = RSP_EMPTY;
        end else begin
          state_nxt_s = RSP_FULL;
        end
      end
      default: state_nxt_s = RSP_EMPTY;
    endcase
  end

  // Result data register; holds its last value when nothing transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= {WORD_W{1'b0}};
      carry_r <= 1'b0;
      id_r    <= {IDW{1'b0}};
    end else if (xfer_s) begin
      sum_r   <= sum_s[WORD_W-1:0];
      carry_r <= sum_s[WORD_W];
      id_r    <= gnt_idx_s;
    end else begin
      sum_r   <= sum_r;
      carry_r <= carry_r;
      id_r    <= id_r;
    end
  end

  // Drive the channel outputs from state and registers; grant is combinational.
  always_comb begin
    bus.req_ready = gnt_s;
    bus.rsp_valid = (state_r == RSP_FULL);
    bus.rsp_sum   = sum_r;
    bus.rsp_carry = carry_r;
    bus.rsp_id    = id_r;
  end

endmodule
